// File: rtl/cache_controller.sv
// Control FSM for a set-associative write-back cache datapath: sequences lookup,
// write hit, write-back and refill, and keeps saturating hit/miss/write-back counters.
module cache_controller #(
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 cpu_valid,
    input  logic                 cpu_req_type,
    output logic                 cpu_ready,
    output logic                 busy,
    input  logic                 hit,
    input  logic                 dirty_bit,
    output logic                 req_type,
    output logic                 read_en_cache,
    output logic                 write_en_cache,
    output logic                 read_en_mem,
    output logic                 write_en_mem,
    input  logic                 mem_ack,
    output logic [CNT_WIDTH-1:0] hit_count,
    output logic [CNT_WIDTH-1:0] miss_count,
    output logic [CNT_WIDTH-1:0] wb_count,
    output logic [2:0]           state_o
);

    localparam logic [2:0] S_IDLE       = 3'd0;
    localparam logic [2:0] S_COMPARE    = 3'd1;
    localparam logic [2:0] S_CHECK      = 3'd2;
    localparam logic [2:0] S_WRITE_HIT  = 3'd3;
    localparam logic [2:0] S_WRITE_BACK = 3'd4;
    localparam logic [2:0] S_ALLOCATE   = 3'd5;
    localparam logic [2:0] S_DONE       = 3'd6;

    // Counter increment constant; CNT_WIDTH must be at least 2.
    localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};

    logic [2:0]           r_state;
    logic [2:0]           w_next_state;
    logic                 r_replay;
    logic                 r_req_type;
    logic [CNT_WIDTH-1:0] r_hit_cnt;
    logic [CNT_WIDTH-1:0] r_miss_cnt;
    logic [CNT_WIDTH-1:0] r_wb_cnt;
    logic                 w_inc_hit;
    logic                 w_inc_miss;
    logic                 w_inc_wb;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:       if (cpu_valid) w_next_state = S_COMPARE;
            S_COMPARE:    w_next_state = S_CHECK;
            S_CHECK: begin
                if (hit) begin
                    w_next_state = r_req_type ? S_WRITE_HIT : S_DONE;
                end else if (dirty_bit && !r_replay) begin
                    w_next_state = S_WRITE_BACK;
                end else begin
                    // A miss after refill is a datapath fault; refill again rather than stall.
                    w_next_state = S_ALLOCATE;
                end
            end
            S_WRITE_HIT:  w_next_state = S_DONE;
            S_WRITE_BACK: if (mem_ack) w_next_state = S_ALLOCATE;
            S_ALLOCATE:   if (mem_ack) w_next_state = S_COMPARE;
            S_DONE:       w_next_state = S_IDLE;
            default:      w_next_state = S_IDLE;
        endcase
    end

    always_comb begin
        read_en_cache  = 1'b0;
        write_en_cache = 1'b0;
        read_en_mem    = 1'b0;
        write_en_mem   = 1'b0;
        cpu_ready      = 1'b0;
        case (r_state)
            S_COMPARE:    read_en_cache = 1'b1;
            S_CHECK:      read_en_cache = 1'b1;
            S_WRITE_HIT:  write_en_cache = 1'b1;
            S_WRITE_BACK: begin
                read_en_cache = 1'b1;
                write_en_mem  = 1'b1;
            end
            S_ALLOCATE: begin
                read_en_mem    = 1'b1;
                write_en_cache = 1'b1;
            end
            S_DONE:       cpu_ready = 1'b1;
            default:      cpu_ready = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_req_type <= 1'b0;
            r_replay   <= 1'b0;
        end else if (r_state == S_IDLE && cpu_valid) begin
            r_req_type <= cpu_req_type;
            r_replay   <= 1'b0;
        end else if (r_state == S_ALLOCATE && mem_ack) begin
            r_replay   <= 1'b1;
        end
    end

    // Only the first lookup of a request is counted; the post-refill lookup is not.
    assign w_inc_hit  = (r_state == S_CHECK) && hit && !r_replay;
    assign w_inc_miss = (r_state == S_CHECK) && !hit && !r_replay;
    assign w_inc_wb   = (r_state == S_WRITE_BACK) && mem_ack;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hit_cnt  <= '0;
            r_miss_cnt <= '0;
            r_wb_cnt   <= '0;
        end else begin
            if (w_inc_hit && r_hit_cnt != CNT_MAX)   r_hit_cnt  <= r_hit_cnt + CNT_ONE;
            if (w_inc_miss && r_miss_cnt != CNT_MAX) r_miss_cnt <= r_miss_cnt + CNT_ONE;
            if (w_inc_wb && r_wb_cnt != CNT_MAX)     r_wb_cnt   <= r_wb_cnt + CNT_ONE;
        end
    end

    assign busy       = (r_state != S_IDLE);
    assign req_type   = r_req_type;
    assign hit_count  = r_hit_cnt;
    assign miss_count = r_miss_cnt;
    assign wb_count   = r_wb_cnt;
    assign state_o    = r_state;

endmodule

// File: tb/tb_cache_controller.sv
// Bench for cache_controller: a reactive datapath/memory responder plus directed
// vectors and randomized transactions checked against a rule-based model.
module tb_cache_controller;

    typedef struct {
        bit rt;
        bit hit;
        bit dirty;
        int w;
        int a;
        int extra;
        int lat;
        int wec;
        int rem;
        int wem;
        int rec;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cpu_valid;
    logic        cpu_req_type;
    logic        hit;
    logic        dirty_bit;
    logic        mem_ack;
    logic        cpu_ready, busy, req_type;
    logic        read_en_cache, write_en_cache, read_en_mem, write_en_mem;
    logic [15:0] hit_count, miss_count, wb_count;
    logic [2:0]  state_o;
    logic        s_cpu_ready, s_busy, s_req_type;
    logic        s_rec, s_wec, s_rem, s_wem;
    logic [1:0]  s_hit_count, s_miss_count, s_wb_count;
    logic [2:0]  s_state_o;

    int n_cmp = 0;
    int n_bad = 0;
    int m_hit = 0, m_miss = 0, m_wb = 0;
    bit cfg_hit = 1'b1, cfg_dirty = 1'b0, stray_en = 1'b0;
    int cfg_w = 1, cfg_a = 1, cfg_extra = 0;
    int wb_cnt = 0, al_cnt = 0, miss_left = 0;
    vec_t table_v[8];

    always #5 clk = ~clk;

    cache_controller #(.CNT_WIDTH(16)) dut (
        .clk(clk), .rst_n(rst_n), .cpu_valid(cpu_valid), .cpu_req_type(cpu_req_type),
        .cpu_ready(cpu_ready), .busy(busy), .hit(hit), .dirty_bit(dirty_bit),
        .req_type(req_type), .read_en_cache(read_en_cache), .write_en_cache(write_en_cache),
        .read_en_mem(read_en_mem), .write_en_mem(write_en_mem), .mem_ack(mem_ack),
        .hit_count(hit_count), .miss_count(miss_count), .wb_count(wb_count), .state_o(state_o)
    );

    // Narrow-counter twin sees identical stimulus; only its counters differ.
    cache_controller #(.CNT_WIDTH(2)) dut_sat (
        .clk(clk), .rst_n(rst_n), .cpu_valid(cpu_valid), .cpu_req_type(cpu_req_type),
        .cpu_ready(s_cpu_ready), .busy(s_busy), .hit(hit), .dirty_bit(dirty_bit),
        .req_type(s_req_type), .read_en_cache(s_rec), .write_en_cache(s_wec),
        .read_en_mem(s_rem), .write_en_mem(s_wem), .mem_ack(mem_ack),
        .hit_count(s_hit_count), .miss_count(s_miss_count), .wb_count(s_wb_count),
        .state_o(s_state_o)
    );

    // Datapath/memory responder: acks after the configured wait, hits after refill.
    always @(negedge clk) begin
        bit ack;
        if (!rst_n || state_o == 3'd0) begin
            hit       = cfg_hit;
            dirty_bit = cfg_dirty;
            miss_left = cfg_extra;
        end
        wb_cnt = write_en_mem ? wb_cnt + 1 : 0;
        al_cnt = read_en_mem ? al_cnt + 1 : 0;
        ack = (write_en_mem && wb_cnt == cfg_w) || (read_en_mem && al_cnt == cfg_a);
        if (read_en_mem && ack) begin
            dirty_bit = 1'b0;
            if (miss_left > 0) begin
                miss_left = miss_left - 1;
                hit = 1'b0;
            end else begin
                hit = 1'b1;
            end
        end
        if (!write_en_mem && !read_en_mem && stray_en) ack = bit'($urandom_range(0, 1));
        mem_ack = ack;
    end

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic int sat3(input int x);
        return (x > 3) ? 3 : x;
    endfunction

    function automatic vec_t model(input vec_t v);
        vec_t r = v;
        int lookups = v.hit ? 1 : 2 + v.extra;
        r.wem = (!v.hit && v.dirty) ? v.w : 0;
        r.rem = v.hit ? 0 : v.a * (1 + v.extra);
        r.wec = r.rem + int'(v.rt);
        r.rec = 2 * lookups + r.wem;
        r.lat = v.hit ? 3 + int'(v.rt)
                      : 3 + int'(v.rt) + r.wem + (v.a + 2) * (1 + v.extra);
        return r;
    endfunction

    task automatic check_counters(input string tag);
        chk({tag, "_hit_count"}, int'(hit_count), m_hit);
        chk({tag, "_miss_count"}, int'(miss_count), m_miss);
        chk({tag, "_wb_count"}, int'(wb_count), m_wb);
        chk({tag, "_sat_hit"}, int'(s_hit_count), sat3(m_hit));
        chk({tag, "_sat_miss"}, int'(s_miss_count), sat3(m_miss));
        chk({tag, "_sat_wb"}, int'(s_wb_count), sat3(m_wb));
    endtask

    task automatic run_txn(input string tag, input vec_t v);
        int lat = 0, wec = 0, rem = 0, wem = 0, rec = 0, both = 0;
        bit done = 1'b0;
        bit rt_seen = 1'b0;
        cfg_hit = v.hit; cfg_dirty = v.dirty; cfg_w = v.w; cfg_a = v.a; cfg_extra = v.extra;
        @(negedge clk);
        chk({tag, "_idle_state"}, int'(state_o), 0);
        chk({tag, "_ready_low"}, int'(cpu_ready), 0);
        cpu_valid = 1'b1;
        cpu_req_type = v.rt;
        while (!done && lat < 200) begin
            @(negedge clk);
            lat++;
            wec += int'(write_en_cache);
            rem += int'(read_en_mem);
            wem += int'(write_en_mem);
            rec += int'(read_en_cache);
            both += int'(read_en_mem && write_en_mem);
            if (state_o == 3'd3) rt_seen = req_type;
            if (cpu_ready) done = 1'b1;
        end
        cpu_valid = 1'b0;
        if (!done) chk({tag, "_timeout"}, 0, 1);
        chk({tag, "_latency"}, lat, v.lat);
        chk({tag, "_wec_cycles"}, wec, v.wec);
        chk({tag, "_rem_cycles"}, rem, v.rem);
        chk({tag, "_wem_cycles"}, wem, v.wem);
        chk({tag, "_rec_cycles"}, rec, v.rec);
        chk({tag, "_mem_both"}, both, 0);
        chk({tag, "_req_type"}, int'(req_type), int'(v.rt));
        if (v.rt && v.hit) chk({tag, "_req_type_in_write_hit"}, int'(rt_seen), 1);
        chk({tag, "_busy_done"}, int'(busy), 1);
        if (v.hit) m_hit++; else m_miss++;
        if (!v.hit && v.dirty) m_wb++;
        check_counters(tag);
        $display("txn %s rt=%0d hit=%0d dirty=%0d w=%0d a=%0d extra=%0d lat=%0d", tag,
                 v.rt, v.hit, v.dirty, v.w, v.a, v.extra, lat);
    endtask

    initial begin
        vec_t v;
        //              rt hit dirty w a extra lat wec rem wem rec
        table_v[0] = '{1'b0, 1'b1, 1'b0, 1, 1, 0, 3, 0, 0, 0, 2};
        table_v[1] = '{1'b1, 1'b1, 1'b0, 1, 1, 0, 4, 1, 0, 0, 2};
        table_v[2] = '{1'b0, 1'b0, 1'b0, 1, 3, 0, 8, 3, 3, 0, 4};
        table_v[3] = '{1'b0, 1'b0, 1'b1, 2, 1, 0, 8, 1, 1, 2, 6};
        table_v[4] = '{1'b1, 1'b0, 1'b0, 1, 1, 0, 7, 2, 1, 0, 4};
        table_v[5] = '{1'b0, 1'b0, 1'b0, 1, 1, 0, 6, 1, 1, 0, 4};
        table_v[6] = '{1'b0, 1'b0, 1'b0, 1, 1, 1, 9, 2, 2, 0, 6};
        table_v[7] = '{1'b1, 1'b0, 1'b1, 1, 2, 0, 9, 3, 2, 1, 5};

        rst_n = 1'b0; cpu_valid = 1'b0; cpu_req_type = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_state", int'(state_o), 0);
        chk("reset_busy", int'(busy), 0);
        chk("reset_ready", int'(cpu_ready), 0);
        chk("reset_enables", int'({read_en_cache, write_en_cache, read_en_mem, write_en_mem}), 0);
        chk("reset_req_type", int'(req_type), 0);
        check_counters("reset");
        rst_n = 1'b1;

        for (int i = 0; i < 8; i++) run_txn($sformatf("vec%0d", i), table_v[i]);

        stray_en = 1'b1;
        for (int i = 0; i < 40; i++) begin
            v.rt    = bit'($urandom_range(0, 1));
            v.hit   = bit'($urandom_range(0, 1));
            v.dirty = bit'($urandom_range(0, 1));
            v.w     = int'($urandom_range(1, 4));
            v.a     = int'($urandom_range(1, 4));
            v.extra = ($urandom_range(0, 7) == 0) ? 1 : 0;
            run_txn($sformatf("rnd%0d", i), model(v));
        end
        stray_en = 1'b0;

        // Asynchronous reset in the middle of a write-back.
        cfg_hit = 1'b0; cfg_dirty = 1'b1; cfg_w = 6; cfg_a = 2; cfg_extra = 0;
        @(negedge clk);
        cpu_valid = 1'b1; cpu_req_type = 1'b0;
        for (int i = 0; i < 20 && !write_en_mem; i++) @(negedge clk);
        chk("rst_mid_wb_reached", int'(write_en_mem), 1);
        cpu_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("rst_mid_state", int'(state_o), 0);
        chk("rst_mid_enables", int'({read_en_cache, write_en_cache, read_en_mem, write_en_mem}), 0);
        chk("rst_mid_busy", int'(busy), 0);
        chk("rst_mid_ready", int'(cpu_ready), 0);
        m_hit = 0; m_miss = 0; m_wb = 0;
        check_counters("rst_mid");
        @(negedge clk);
        rst_n = 1'b1;
        run_txn("post_rst", table_v[0]);

        for (int i = 0; i < 5; i++) run_txn($sformatf("sat%0d", i), table_v[0]);

        // Stray acks while idle must not start anything.
        stray_en = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk($sformatf("idle_stray_state%0d", i), int'(state_o), 0);
            chk($sformatf("idle_stray_busy%0d", i), int'(busy), 0);
        end
        stray_en = 1'b0;
        check_counters("final");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
